sseg_scan_mux: RTL and testbench

Time-multiplexed scanner for the 4-digit common-anode seven-segment display.
- Holds a tear-free 16-bit display value and steps through the digits at a fixed refresh rate.
- For each digit it drives one 4-bit nibble to the downstream binary-to-segment decoder, plus an active-low anode select and an active-low decimal point.
- Provides optional leading-zero blanking.

---
 rtl/sseg_pkg.sv | 22 ++
 rtl/sseg_scan_mux_if.sv | 28 ++
 rtl/sseg_refresh_tick.sv | 32 +++
 rtl/sseg_scan_mux.sv | 109 ++++++++++
 tb/tb_sseg_scan_mux.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants, types and helpers for the seven-segment scanner.
//   NUM_DIGITS / NIBBLE_W : display geometry (4 digits, 4-bit nibble each)
//   digit_idx_t           : index of a digit, 0 = rightmost
//   AN_OFF                : anode pattern with every digit dark (active-low)
//   an_onehot_low()       : active-low one-hot anode pattern for a digit index
package sseg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int NIBBLE_W   = 4;

   typedef logic [1:0] digit_idx_t;

   localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

   function automatic logic [NUM_DIGITS-1:0] an_onehot_low(digit_idx_t idx);
      logic [NUM_DIGITS-1:0] pat;
      pat      = AN_OFF;
      pat[idx] = 1'b0;
      return pat;
   endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// sseg_scan_mux_if: bundle between a display owner (master) and the scanner (slave).
//   master drives : load, value[15:0], dp_mask[3:0], en
//   slave drives  : binary[3:0], an[3:0] (active-low), dp (active-low), digit_sel[1:0]
// Handshake: there is no ready. load is a single-cycle strobe; whenever it is
// high at a rising edge, value/dp_mask are captured on that edge. en is a level.
interface sseg_scan_mux_if;
   import sseg_pkg::*;

   logic                  load;
   logic [15:0]           value;
   logic [NUM_DIGITS-1:0] dp_mask;
   logic                  en;
   logic [NIBBLE_W-1:0]   binary;
   logic [NUM_DIGITS-1:0] an;
   logic                  dp;
   digit_idx_t            digit_sel;

   modport master (
      output load, value, dp_mask, en,
      input  binary, an, dp, digit_sel
   );

   modport slave (
      input  load, value, dp_mask, en,
      output binary, an, dp, digit_sel
   );

endinterface

// File: rtl/sseg_refresh_tick.sv
// sseg_refresh_tick: free-running prescaler that sets the digit slot rate.
//   clk, reset : clock and synchronous active-high reset
//   tick       : high for exactly one cycle out of every TICK_DIV (count == TICK_DIV-1)
// TICK_DIV must be 2 or more.
module sseg_refresh_tick #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int              CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: time-multiplexed scanner for a 4-digit common-anode display.
//   clk, reset : clock and synchronous active-high reset
//   bus        : sseg_scan_mux_if.slave
//                inputs  load/value/dp_mask (shadow capture), en (display enable)
//                outputs binary (nibble to segment decoder), an (active-low anodes),
//                        dp (active-low decimal point), digit_sel (digit on display)
// A shadow copy of value/dp_mask keeps a scan round tear-free. Each prescaler
// tick registers the next digit onto the outputs; outputs hold between ticks,
// except that en=0 darkens the display on the very next edge.
module sseg_scan_mux
   import sseg_pkg::*;
#(
   parameter int TICK_DIV = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input logic           clk,
   input logic           reset,
   sseg_scan_mux_if.slave bus
);

   logic tick;

   sseg_refresh_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   logic [15:0]           value_q,     value_d;
   logic [NUM_DIGITS-1:0] dp_mask_q,   dp_mask_d;
   digit_idx_t            idx_q,       idx_d;
   logic [NIBBLE_W-1:0]   binary_q,    binary_d;
   logic [NUM_DIGITS-1:0] an_q,        an_d;
   logic                  dp_q,        dp_d;
   digit_idx_t            digit_sel_q, digit_sel_d;

   logic [NUM_DIGITS-1:0] blank;
   logic                  lit;

   // A digit is a leading zero when it and every digit to its left hold zero
   // and request no decimal point; built from the left so each bit reuses the
   // one above it. Digit 0 always shows.
   always_comb begin
      blank = '0;
      if (BLANK_LZ) begin
         blank[NUM_DIGITS-1] = (value_q[NIBBLE_W*(NUM_DIGITS-1) +: NIBBLE_W] == '0) &&
                               !dp_mask_q[NUM_DIGITS-1];
         for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
            blank[k] = blank[k+1] &&
                       (value_q[NIBBLE_W*k +: NIBBLE_W] == '0) && !dp_mask_q[k];
         end
      end
   end

   always_comb begin
      value_d     = value_q;
      dp_mask_d   = dp_mask_q;
      idx_d       = idx_q;
      binary_d    = binary_q;
      an_d        = an_q;
      dp_d        = dp_q;
      digit_sel_d = digit_sel_q;
      lit         = bus.en && !blank[idx_q];

      // A load coinciding with a tick lands in the shadow only after the tick
      // has sampled the old contents, so that slot shows the old nibble.
      if (bus.load) begin
         value_d   = bus.value;
         dp_mask_d = bus.dp_mask;
      end

      if (tick) begin
         binary_d    = value_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
         digit_sel_d = idx_q;
         an_d        = lit ? an_onehot_low(idx_q) : AN_OFF;
         dp_d        = lit ? ~dp_mask_q[idx_q] : 1'b1;
         idx_d       = idx_q + 2'd1;
      end else if (!bus.en) begin
         an_d = AN_OFF;
         dp_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q     <= '0;
         dp_mask_q   <= '0;
         idx_q       <= '0;
         binary_q    <= '0;
         an_q        <= AN_OFF;
         dp_q        <= 1'b1;
         digit_sel_q <= '0;
      end else begin
         value_q     <= value_d;
         dp_mask_q   <= dp_mask_d;
         idx_q       <= idx_d;
         binary_q    <= binary_d;
         an_q        <= an_d;
         dp_q        <= dp_d;
         digit_sel_q <= digit_sel_d;
      end
   end

   assign bus.binary    = binary_q;
   assign bus.an        = an_q;
   assign bus.dp        = dp_q;
   assign bus.digit_sel = digit_sel_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: drives two scanners (leading-zero blanking on and off) from
// one stimulus stream and checks them every cycle against a slot-level model.
module tb_sseg_scan_mux;

   localparam int TD = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        load    = 1'b0;
   logic [15:0] value   = '0;
   logic [3:0]  dp_mask = '0;
   logic        en      = 1'b0;

   sseg_scan_mux_if bus_lz ();
   sseg_scan_mux_if bus_all ();

   assign bus_lz.load     = load;
   assign bus_lz.value    = value;
   assign bus_lz.dp_mask  = dp_mask;
   assign bus_lz.en       = en;
   assign bus_all.load    = load;
   assign bus_all.value   = value;
   assign bus_all.dp_mask = dp_mask;
   assign bus_all.en      = en;

   sseg_scan_mux #(.TICK_DIV(TD), .BLANK_LZ(1'b1)) dut_lz (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_lz)
   );

   sseg_scan_mux #(.TICK_DIV(TD), .BLANK_LZ(1'b0)) dut_all (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_all)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Slot view: the n-th cycle after reset is a tick when n % TD == TD-1;
   // the t-th tick shows digit t % 4 from the shadow value.
   int          m_cycles;
   int          m_ticks;
   logic [15:0] m_val;
   logic [3:0]  m_dpm;
   bit          m_tick;
   int          m_idx;
   bit          m_lit;
   logic [3:0]  e_an [2];
   logic        e_dp [2];
   logic [3:0]  e_bin;
   logic [1:0]  e_sel;

   function automatic bit blanked(bit lz, logic [15:0] v, logic [3:0] d, int k);
      if (!lz || k == 0) return 1'b0;
      return ((v >> (4 * k)) == 16'h0) && ((d >> k) == 4'h0);
   endfunction

   always @(posedge clk) begin
      m_tick = 1'b0;
      if (reset) begin
         m_cycles = 0;
         m_ticks  = 0;
         m_val    = '0;
         m_dpm    = '0;
         e_bin    = '0;
         e_sel    = '0;
         for (int b = 0; b < 2; b++) begin
            e_an[b] = 4'hF;
            e_dp[b] = 1'b1;
         end
      end else begin
         if (m_cycles % TD == TD - 1) begin
            m_tick = 1'b1;
            m_idx  = m_ticks % 4;
            e_bin  = 4'((m_val >> (4 * m_idx)) & 16'hF);
            e_sel  = 2'(m_idx);
            for (int b = 0; b < 2; b++) begin
               m_lit   = en && !blanked(b == 0, m_val, m_dpm, m_idx);
               e_an[b] = m_lit ? ~(4'b0001 << m_idx) : 4'hF;
               e_dp[b] = m_lit ? ~m_dpm[m_idx] : 1'b1;
            end
            m_ticks++;
         end else if (!en) begin
            for (int b = 0; b < 2; b++) begin
               e_an[b] = 4'hF;
               e_dp[b] = 1'b1;
            end
         end
         if (load) begin
            m_val = value;
            m_dpm = dp_mask;
         end
         m_cycles++;
      end
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(posedge clk) begin
      #1;
      if (cmp_en) begin
         check("an_lz",      16'(bus_lz.an),         16'(e_an[0]));
         check("dp_lz",      16'(bus_lz.dp),         16'(e_dp[0]));
         check("bin_lz",     16'(bus_lz.binary),     16'(e_bin));
         check("sel_lz",     16'(bus_lz.digit_sel),  16'(e_sel));
         check("an_all",     16'(bus_all.an),        16'(e_an[1]));
         check("dp_all",     16'(bus_all.dp),        16'(e_dp[1]));
         check("bin_all",    16'(bus_all.binary),    16'(e_bin));
         check("sel_all",    16'(bus_all.digit_sel), 16'(e_sel));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] d);
      value   = v;
      dp_mask = d;
      load    = 1'b1;
      edge1();
      load    = 1'b0;
   endtask

   task automatic wait_slot(input int k);
      int n = 0;
      do begin
         edge1();
         n++;
      end while (!(m_tick && m_idx == k) && n < 40);
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL wait_slot_%0d timeout after %0d cycles", k, n);
      end
   endtask

   // ---------------- directed + random stimulus ----------------
   logic [3:0] s1_an  [4];
   logic [3:0] s1_bin [4];

   initial begin
      s1_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      s1_bin = '{4'h4, 4'h3, 4'h2, 4'h1};

      reset = 1'b1;
      repeat (2) edge1();
      cmp_en = 1'b1;
      check("reset_an",  16'(bus_lz.an), 16'hF);
      check("reset_dp",  16'(bus_lz.dp), 16'h1);
      check("reset_bin", 16'(bus_lz.binary), 16'h0);

      // Scan of 0x1234: dark until the TD-th edge, then digits 0..3 twice.
      reset   = 1'b0;
      value   = 16'h1234;
      dp_mask = 4'h0;
      en      = 1'b1;
      load    = 1'b1;
      edge1();
      load = 1'b0;
      check("s1_dark_c1", 16'(bus_lz.an), 16'hF);
      repeat (2) edge1();
      check("s1_dark_c3", 16'(bus_lz.an), 16'hF);
      for (int i = 0; i < 8; i++) begin
         repeat ((i == 0) ? 1 : 4) edge1();
         check("s1_an",  16'(bus_lz.an),     16'(s1_an[i % 4]));
         check("s1_bin", 16'(bus_lz.binary), 16'(s1_bin[i % 4]));
         check("s1_dp",  16'(bus_lz.dp),     16'h1);
      end

      // Load 0xABCD on the tick edge: that slot still shows the old nibble.
      repeat (3) edge1();
      value = 16'hABCD;
      load  = 1'b1;
      edge1();
      load = 1'b0;
      check("s5_old_an",  16'(bus_lz.an),     16'hE);
      check("s5_old_bin", 16'(bus_lz.binary), 16'h4);
      repeat (4) edge1();
      check("s5_new_an",  16'(bus_lz.an),     16'hD);
      check("s5_new_bin", 16'(bus_lz.binary), 16'hC);

      // Leading-zero blanking of 0x0005, then with a decimal point on digit 2.
      load_val(16'h0005, 4'b0000);
      wait_slot(3);
      wait_slot(0);
      check("s2_d0_an",  16'(bus_lz.an),     16'hE);
      check("s2_d0_bin", 16'(bus_lz.binary), 16'h5);
      wait_slot(1);
      check("s2_d1_lz",  16'(bus_lz.an),     16'hF);
      check("s2_d1_all", 16'(bus_all.an),    16'hD);
      check("s2_d1_bin", 16'(bus_all.binary), 16'h0);
      wait_slot(3);
      check("s2_d3_all", 16'(bus_all.an),    16'h7);
      load_val(16'h0005, 4'b0100);
      wait_slot(3);
      wait_slot(2);
      check("s2_dp_an", 16'(bus_lz.an), 16'hB);
      check("s2_dp_dp", 16'(bus_lz.dp), 16'h0);
      wait_slot(3);
      check("s2_dp_d3", 16'(bus_lz.an), 16'hF);

      // All-zero value: only digit 0 lit.
      load_val(16'h0000, 4'b0000);
      wait_slot(3);
      wait_slot(0);
      check("s3_d0_an",  16'(bus_lz.an),     16'hE);
      check("s3_d0_bin", 16'(bus_lz.binary), 16'h0);
      wait_slot(2);
      check("s3_d2_an",  16'(bus_lz.an),     16'hF);

      // Enable dropped during digit 2, restored while digit 1 is next.
      load_val(16'h1234, 4'b0000);
      wait_slot(3);
      wait_slot(2);
      check("s4_lit", 16'(bus_lz.an), 16'hB);
      en = 1'b0;
      edge1();
      check("s4_off_an", 16'(bus_lz.an), 16'hF);
      check("s4_off_dp", 16'(bus_lz.dp), 16'h1);
      wait_slot(3);
      check("s4_sel_steps", 16'(bus_lz.digit_sel), 16'h3);
      wait_slot(0);
      en = 1'b1;
      wait_slot(1);
      check("s4_resume_an",  16'(bus_lz.an),     16'hD);
      check("s4_resume_bin", 16'(bus_lz.binary), 16'h3);

      // Reset while digit 2 is on display.
      wait_slot(2);
      reset = 1'b1;
      edge1();
      reset = 1'b0;
      check("s6_an",  16'(bus_lz.an),        16'hF);
      check("s6_sel", 16'(bus_lz.digit_sel), 16'h0);
      repeat (3) edge1();
      check("s6_dark", 16'(bus_lz.an), 16'hF);
      edge1();
      check("s6_first_an",  16'(bus_lz.an),     16'hE);
      check("s6_first_bin", 16'(bus_lz.binary), 16'h0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         load = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       value = 16'($urandom);
            1:       value = 16'($urandom_range(0, 15));
            2:       value = 16'($urandom_range(0, 255));
            default: value = 16'h0;
         endcase
         dp_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         en      = ($urandom_range(0, 9) != 0);
         reset   = ($urandom_range(0, 299) == 0);
         edge1();
      end
      reset = 1'b0;
      load  = 1'b0;
      edge1();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
